// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
// Round-robin arbiter sharing the single write port of the async FIFO among
// NUM_REQ requesters in the wclk domain. A requester is granted for one burst
// of 1..MAX_BURST beats. Its beats are streamed while the FIFO is not full,
// and priority then rotates to the requester after the winner.
//
// Ports
//   wclk        write-domain clock
//   w_rstn      synchronous active-low reset
//   req         per-requester request level
//   req_len     packed burst lengths, requester i at [i*LEN_W +: LEN_W]
//   req_data    packed beat data, requester i at [i*DATA_SIZE +: DATA_SIZE]
//   fifo_full   FIFO full flag
//   grant       one-hot registered grant (zero when idle)
//   data_ack    one-hot pulse: granted requester's beat written this cycle
//   fifo_w_en   FIFO write enable
//   fifo_w_data beat data of the granted requester (zero when idle)
//   busy        high while a burst is in progress
//   beat_count  total beats written, wraps at 2^16
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_SIZE = 32,
  parameter int MAX_BURST = 8,
  parameter int LEN_W     = $clog2(MAX_BURST) + 1
) (
  input  logic                          wclk,
  input  logic                          w_rstn,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*LEN_W-1:0]      req_len,
  input  logic [NUM_REQ*DATA_SIZE-1:0]  req_data,
  input  logic                          fifo_full,
  output logic [NUM_REQ-1:0]            grant,
  output logic [NUM_REQ-1:0]            data_ack,
  output logic                          fifo_w_en,
  output logic [DATA_SIZE-1:0]          fifo_w_data,
  output logic                          busy,
  output logic [15:0]                   beat_count
);

  localparam int unsigned        N_REQ     = NUM_REQ;
  localparam int                 IDX_W     = $clog2(NUM_REQ);
  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_REQ - 1);
  localparam logic [LEN_W-1:0]   LEN_ONE   = LEN_W'(1);
  localparam logic [LEN_W-1:0]   LEN_MAX   = LEN_W'(MAX_BURST);
  localparam logic [NUM_REQ-1:0] GRANT_LSB = NUM_REQ'(1);

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  state_t               state_q;
  logic [NUM_REQ-1:0]   grant_q;
  logic [IDX_W-1:0]     winner_q;
  logic [IDX_W-1:0]     rr_ptr_q;
  logic [LEN_W-1:0]     beats_left_q;
  logic [15:0]          beat_count_q;

  logic [IDX_W-1:0]     rr_ptr_d;
  logic [15:0]          beat_count_d;
  logic                 pick_vld;
  logic [IDX_W-1:0]     pick_idx;
  logic [LEN_W-1:0]     raw_len;
  logic [LEN_W-1:0]     pick_len;
  logic                 win_req;
  int unsigned          scan_idx;

  // Search from rr_ptr upward, wrapping modulo NUM_REQ; first set request wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    scan_idx = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      scan_idx = 32'(rr_ptr_q) + i;
      if (scan_idx >= N_REQ) scan_idx = scan_idx - N_REQ;
      if (!pick_vld && req[scan_idx[IDX_W-1:0]]) begin
        pick_vld = 1'b1;
        pick_idx = scan_idx[IDX_W-1:0];
      end
    end
  end

  // Length sampled at grant: 0 becomes 1, anything above MAX_BURST is clamped.
  always_comb begin
    raw_len = req_len[32'(pick_idx)*LEN_W +: LEN_W];
    if (raw_len == '0)
      pick_len = LEN_ONE;
    else if (raw_len > LEN_MAX)
      pick_len = LEN_MAX;
    else
      pick_len = raw_len;
  end

  assign busy        = (state_q == BURST);
  assign win_req     = req[winner_q];
  // Abort (req dropped) and full both suppress the write.
  assign fifo_w_en   = busy & win_req & ~fifo_full;
  assign data_ack    = fifo_w_en ? grant_q : '0;
  assign fifo_w_data = busy ? req_data[32'(winner_q)*DATA_SIZE +: DATA_SIZE] : '0;
  assign grant       = grant_q;
  assign beat_count  = beat_count_q;

  assign rr_ptr_d     = (winner_q == LAST_IDX) ? '0 : winner_q + 1'b1;
  assign beat_count_d = fifo_w_en ? beat_count_q + 16'd1 : beat_count_q;

  always_ff @(posedge wclk) begin
    if (!w_rstn) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      winner_q     <= '0;
      rr_ptr_q     <= '0;
      beats_left_q <= '0;
      beat_count_q <= '0;
    end else begin
      beat_count_q <= beat_count_d;
      case (state_q)
        IDLE: begin
          if (pick_vld) begin
            state_q      <= BURST;
            winner_q     <= pick_idx;
            grant_q      <= GRANT_LSB << pick_idx;
            beats_left_q <= pick_len;
          end
        end
        BURST: begin
          if (!win_req) begin
            // Abort: leave without writing, rotate as on completion.
            state_q      <= IDLE;
            grant_q      <= '0;
            rr_ptr_q     <= rr_ptr_d;
            beats_left_q <= '0;
          end else if (fifo_w_en) begin
            beats_left_q <= beats_left_q - LEN_ONE;
            if (beats_left_q == LEN_ONE) begin
              state_q  <= IDLE;
              grant_q  <= '0;
              rr_ptr_q <= rr_ptr_d;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Testbench for fifo_wr_arbiter: directed scenarios with hand-computed
// per-cycle expectations. Cycle 0 is the cycle following the last reset edge;
// inputs change 1 time unit after a rising edge, outputs sampled on falling edge.
module tb_fifo_wr_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int DATA_SIZE = 32;
  localparam int MAX_BURST = 8;
  localparam int LEN_W     = 4;

  logic                         wclk;
  logic                         w_rstn;
  logic [NUM_REQ-1:0]           req;
  logic [NUM_REQ*LEN_W-1:0]     req_len;
  logic [NUM_REQ*DATA_SIZE-1:0] req_data;
  logic                         fifo_full;
  logic [NUM_REQ-1:0]           grant;
  logic [NUM_REQ-1:0]           data_ack;
  logic                         fifo_w_en;
  logic [DATA_SIZE-1:0]         fifo_w_data;
  logic                         busy;
  logic [15:0]                  beat_count;

  int checks   = 0;
  int failures = 0;

  fifo_wr_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .DATA_SIZE(DATA_SIZE),
    .MAX_BURST(MAX_BURST),
    .LEN_W    (LEN_W)
  ) dut (
    .wclk       (wclk),
    .w_rstn     (w_rstn),
    .req        (req),
    .req_len    (req_len),
    .req_data   (req_data),
    .fifo_full  (fifo_full),
    .grant      (grant),
    .data_ack   (data_ack),
    .fifo_w_en  (fifo_w_en),
    .fifo_w_data(fifo_w_data),
    .busy       (busy),
    .beat_count (beat_count)
  );

  initial begin
    wclk = 1'b0;
    forever #5 wclk = ~wclk;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic set_len(input int unsigned i, input logic [LEN_W-1:0] v);
    req_len[i*LEN_W +: LEN_W] = v;
  endtask

  task automatic set_data(input int unsigned i, input logic [DATA_SIZE-1:0] v);
    req_data[i*DATA_SIZE +: DATA_SIZE] = v;
  endtask

  // Two reset edges, then release; returns 1 unit after the edge into cycle 0.
  task automatic do_reset();
    w_rstn    = 1'b0;
    req       = '0;
    req_len   = '0;
    req_data  = '0;
    fifo_full = 1'b0;
    @(posedge wclk);
    @(posedge wclk);
    #1;
    w_rstn = 1'b1;
  endtask

  task automatic test_reset();
    w_rstn    = 1'b0;
    req       = 4'hF;
    req_len   = 16'h3333;
    req_data  = {32'h44, 32'h33, 32'h22, 32'h11};
    fifo_full = 1'b0;
    @(posedge wclk);
    #1;
    @(negedge wclk);
    checks++; if (grant !== 4'h0) begin failures++; $display("FAIL reset_grant got=%h exp=0", grant); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (fifo_w_en !== 1'b0) begin failures++; $display("FAIL reset_w_en got=%b exp=0", fifo_w_en); end
    checks++; if (data_ack !== 4'h0) begin failures++; $display("FAIL reset_ack got=%h exp=0", data_ack); end
    checks++; if (fifo_w_data !== 32'h0) begin failures++; $display("FAIL reset_w_data got=%h exp=0", fifo_w_data); end
    checks++; if (beat_count !== 16'h0) begin failures++; $display("FAIL reset_beat_count got=%h exp=0", beat_count); end
    checks++; if (dut.beats_left_q !== 4'h0) begin failures++; $display("FAIL reset_beats_left got=%h exp=0", dut.beats_left_q); end
  endtask

  task automatic test_single();
    logic [3:0]  exp_g [5] = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h0};
    logic [31:0] exp_d [5] = '{32'h0, 32'hA, 32'hB, 32'hC, 32'h0};
    do_reset();
    req = 4'b0001;
    set_len(0, 4'd3);
    set_data(0, 32'hA);
    for (int unsigned c = 0; c < 5; c++) begin
      if (c != 0) begin
        @(posedge wclk);
        #1;
        if (c == 2) set_data(0, 32'hB);
        if (c == 3) set_data(0, 32'hC);
        if (c == 4) begin
          set_data(0, 32'hD);
          req = '0;
        end
      end
      @(negedge wclk);
      checks++; if (grant !== exp_g[c]) begin failures++; $display("FAIL single_grant c=%0d got=%h exp=%h", c, grant, exp_g[c]); end
      checks++; if (fifo_w_en !== (|exp_g[c])) begin failures++; $display("FAIL single_w_en c=%0d got=%b exp=%b", c, fifo_w_en, |exp_g[c]); end
      checks++; if (data_ack !== exp_g[c]) begin failures++; $display("FAIL single_ack c=%0d got=%h exp=%h", c, data_ack, exp_g[c]); end
      checks++; if (fifo_w_data !== exp_d[c]) begin failures++; $display("FAIL single_w_data c=%0d got=%h exp=%h", c, fifo_w_data, exp_d[c]); end
    end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_idle got=%b exp=0", busy); end
    checks++; if (beat_count !== 16'd3) begin failures++; $display("FAIL single_beat_count got=%0d exp=3", beat_count); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g [15] = '{4'h0, 4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h0, 4'h4,
                               4'h4, 4'h0, 4'h8, 4'h8, 4'h0, 4'h1, 4'h1};
    logic [31:0] ed;
    do_reset();
    req = 4'hF;
    for (int unsigned i = 0; i < 4; i++) begin
      set_len(i, 4'd2);
      set_data(i, 32'h11 * (i + 1));
    end
    for (int unsigned c = 0; c < 15; c++) begin
      if (c != 0) begin
        @(posedge wclk);
        #1;
      end
      @(negedge wclk);
      case (exp_g[c])
        4'h1:    ed = 32'h11;
        4'h2:    ed = 32'h22;
        4'h4:    ed = 32'h33;
        4'h8:    ed = 32'h44;
        default: ed = 32'h0;
      endcase
      checks++; if (grant !== exp_g[c]) begin failures++; $display("FAIL rr_grant c=%0d got=%h exp=%h", c, grant, exp_g[c]); end
      checks++; if (fifo_w_en !== (|exp_g[c])) begin failures++; $display("FAIL rr_w_en c=%0d got=%b exp=%b", c, fifo_w_en, |exp_g[c]); end
      checks++; if (data_ack !== exp_g[c]) begin failures++; $display("FAIL rr_ack c=%0d got=%h exp=%h", c, data_ack, exp_g[c]); end
      checks++; if (fifo_w_data !== ed) begin failures++; $display("FAIL rr_w_data c=%0d got=%h exp=%h", c, fifo_w_data, ed); end
    end
  endtask

  task automatic test_full_stall();
    logic       exp_w  [9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [3:0] exp_bl [9] = '{4'd0, 4'd4, 4'd3, 4'd3, 4'd3, 4'd3, 4'd2, 4'd1, 4'd0};
    logic [31:0] exp_d [9] = '{32'h0, 32'hC0, 32'hC1, 32'hC1, 32'hC1, 32'hC1, 32'hC2, 32'hC3, 32'h0};
    logic [3:0] eg;
    int unsigned writes;
    int unsigned last_wr;
    writes  = 0;
    last_wr = 0;
    do_reset();
    req = 4'b0100;
    set_len(2, 4'd4);
    set_data(2, 32'hC0);
    for (int unsigned c = 0; c < 9; c++) begin
      if (c != 0) begin
        @(posedge wclk);
        #1;
        fifo_full = (c >= 2 && c <= 4);
        if (c == 2) set_data(2, 32'hC1);
        if (c == 6) set_data(2, 32'hC2);
        if (c == 7) set_data(2, 32'hC3);
        if (c == 8) req = '0;
      end
      @(negedge wclk);
      eg = (c >= 1 && c <= 7) ? 4'b0100 : 4'b0000;
      if (fifo_w_en === 1'b1) begin
        writes++;
        last_wr = c;
      end
      checks++; if (grant !== eg) begin failures++; $display("FAIL stall_grant c=%0d got=%h exp=%h", c, grant, eg); end
      checks++; if (fifo_w_en !== exp_w[c]) begin failures++; $display("FAIL stall_w_en c=%0d got=%b exp=%b", c, fifo_w_en, exp_w[c]); end
      checks++; if (data_ack !== (exp_w[c] ? 4'b0100 : 4'b0000)) begin failures++; $display("FAIL stall_ack c=%0d got=%h exp_w=%b", c, data_ack, exp_w[c]); end
      checks++; if (dut.beats_left_q !== exp_bl[c]) begin failures++; $display("FAIL stall_beats_left c=%0d got=%0d exp=%0d", c, dut.beats_left_q, exp_bl[c]); end
      checks++; if (fifo_w_data !== exp_d[c]) begin failures++; $display("FAIL stall_w_data c=%0d got=%h exp=%h", c, fifo_w_data, exp_d[c]); end
    end
    fifo_full = 1'b0;
    checks++; if (writes != 4) begin failures++; $display("FAIL stall_writes got=%0d exp=4", writes); end
    checks++; if (last_wr != 7) begin failures++; $display("FAIL stall_last_write got=%0d exp=7", last_wr); end
    checks++; if (beat_count !== 16'd4) begin failures++; $display("FAIL stall_beat_count got=%0d exp=4", beat_count); end
  endtask

  task automatic test_abort_clamp();
    logic [3:0] exp_g [7] = '{4'h0, 4'h2, 4'h2, 4'h2, 4'h0, 4'h4, 4'h0};
    logic       exp_w [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    do_reset();
    req = 4'b0110;
    set_len(1, 4'd15);
    set_len(2, 4'd1);
    set_data(1, 32'hB0);
    set_data(2, 32'h20);
    for (int unsigned c = 0; c < 7; c++) begin
      if (c != 0) begin
        @(posedge wclk);
        #1;
        if (c == 2) set_data(1, 32'hB1);
        if (c == 3) req[1] = 1'b0;
        if (c == 6) req[2] = 1'b0;
      end
      @(negedge wclk);
      checks++; if (grant !== exp_g[c]) begin failures++; $display("FAIL abort_grant c=%0d got=%h exp=%h", c, grant, exp_g[c]); end
      checks++; if (fifo_w_en !== exp_w[c]) begin failures++; $display("FAIL abort_w_en c=%0d got=%b exp=%b", c, fifo_w_en, exp_w[c]); end
      checks++; if (data_ack !== (exp_w[c] ? exp_g[c] : 4'h0)) begin failures++; $display("FAIL abort_ack c=%0d got=%h exp_w=%b", c, data_ack, exp_w[c]); end
      if (c == 1) begin
        checks++; if (dut.beats_left_q !== 4'd8) begin failures++; $display("FAIL clamp_beats_left got=%0d exp=8", dut.beats_left_q); end
      end
      if (c == 4) begin
        checks++; if (beat_count !== 16'd2) begin failures++; $display("FAIL abort_beat_count got=%0d exp=2", beat_count); end
      end
      if (c == 5) begin
        checks++; if (fifo_w_data !== 32'h20) begin failures++; $display("FAIL abort_next_data got=%h exp=20", fifo_w_data); end
      end
    end

    // Zero length behaves as a single beat; request held throughout.
    do_reset();
    req = 4'b0001;
    set_len(0, 4'd0);
    set_data(0, 32'h77);
    for (int unsigned c = 0; c < 4; c++) begin
      if (c != 0) begin
        @(posedge wclk);
        #1;
      end
      @(negedge wclk);
      checks++; if (fifo_w_en !== (c == 1 || c == 3)) begin failures++; $display("FAIL zero_len_w_en c=%0d got=%b", c, fifo_w_en); end
      if (c == 1) begin
        checks++; if (dut.beats_left_q !== 4'd1) begin failures++; $display("FAIL zero_len_beats_left got=%0d exp=1", dut.beats_left_q); end
      end
      if (c == 2) begin
        checks++; if (grant !== 4'h0) begin failures++; $display("FAIL zero_len_gap_grant got=%h exp=0", grant); end
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    req = 4'b0001;
    set_len(0, 4'd5);
    set_data(0, 32'h50);
    for (int unsigned c = 0; c < 7; c++) begin
      if (c != 0) begin
        @(posedge wclk);
        #1;
        if (c == 2) set_data(0, 32'h51);
        if (c == 3) begin
          set_data(0, 32'h52);
          w_rstn = 1'b0;
        end
        if (c == 4) begin
          w_rstn = 1'b1;
          req    = '0;
        end
      end
      @(negedge wclk);
      if (c == 1 || c == 2) begin
        checks++; if (fifo_w_en !== 1'b1) begin failures++; $display("FAIL rst_mid_w_en c=%0d got=%b exp=1", c, fifo_w_en); end
        checks++; if (fifo_w_data !== (32'h50 + c - 1)) begin failures++; $display("FAIL rst_mid_w_data c=%0d got=%h", c, fifo_w_data); end
      end
      if (c == 4) begin
        checks++; if (grant !== 4'h0) begin failures++; $display("FAIL rst_mid_grant got=%h exp=0", grant); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
        checks++; if (data_ack !== 4'h0) begin failures++; $display("FAIL rst_mid_ack got=%h exp=0", data_ack); end
        checks++; if (fifo_w_data !== 32'h0) begin failures++; $display("FAIL rst_mid_w_data got=%h exp=0", fifo_w_data); end
        checks++; if (beat_count !== 16'h0) begin failures++; $display("FAIL rst_mid_beat_count got=%h exp=0", beat_count); end
      end
      if (c >= 4) begin
        checks++; if (fifo_w_en !== 1'b0) begin failures++; $display("FAIL rst_mid_no_write c=%0d got=%b exp=0", c, fifo_w_en); end
      end
    end
  endtask

  task automatic test_wrap();
    int unsigned cnt;
    int unsigned cyc;
    cnt = 0;
    cyc = 0;
    do_reset();
    req = 4'b0001;
    set_len(0, 4'd8);
    set_data(0, 32'h99);
    while (cnt < 65536 && cyc < 80000) begin
      @(negedge wclk);
      if (fifo_w_en === 1'b1) begin
        cnt++;
        if (cnt == 65536) begin
          checks++; if (beat_count !== 16'hFFFF) begin failures++; $display("FAIL wrap_pre got=%h exp=ffff", beat_count); end
        end
      end
      cyc++;
    end
    checks++; if (cnt != 65536) begin failures++; $display("FAIL wrap_timeout writes=%0d exp=65536", cnt); end
    @(posedge wclk);
    #1;
    req = '0;
    @(negedge wclk);
    checks++; if (beat_count !== 16'h0000) begin failures++; $display("FAIL wrap_post got=%h exp=0000", beat_count); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL wrap_idle got=%b exp=0", busy); end
  endtask

  initial begin
    w_rstn    = 1'b0;
    req       = '0;
    req_len   = '0;
    req_data  = '0;
    fifo_full = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_full_stall();
    test_abort_clamp();
    test_reset_mid_burst();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
